// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO register pair.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3, OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5, OP_MTLO  = 4'd6, OP_MFHI = 4'd7, OP_MFLO = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9, OP_MADDU = 4'd10, OP_MSUB = 4'd11, OP_MSUBU = 4'd12;
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]   shadow_q, shadow_d;

  logic                 is_mul, is_div, mul_sgn, div_sgn;
  logic [2*WIDTH-1:0]   prod, res;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  // Operation decode; accumulate ops are only recognised when the feature is built in.
  always_comb begin
    is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    mul_sgn = (op == OP_MULT);
`ifdef MDU_MADD_EN
    is_mul  = is_mul || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    mul_sgn = mul_sgn || (op == OP_MADD) || (op == OP_MSUB);
`endif
    is_div  = (op == OP_DIV) || (op == OP_DIVU);
    div_sgn = (op == OP_DIV);
  end

  // One multiplier for both signednesses: sign- or zero-extend to 2*WIDTH and keep the low half.
  always_comb begin
    prod = {{WIDTH{mul_sgn & A[WIDTH-1]}}, A} * {{WIDTH{mul_sgn & B[WIDTH-1]}}, B};
  end

  // Sign-magnitude divide; the most-negative / -1 case falls out as LO=A, HI=0.
  always_comb begin
    a_neg  = div_sgn & A[WIDTH-1];
    b_neg  = div_sgn & B[WIDTH-1];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
    b_safe = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
    if (B == '0) begin
      quo = '1;
      rem = A;
    end
  end

  always_comb begin
    res = prod;
    if (is_div) res = {rem, quo};
`ifdef MDU_MADD_EN
    if ((op == OP_MADD) || (op == OP_MADDU)) res = {hi_q, lo_q} + prod;
    if ((op == OP_MSUB) || (op == OP_MSUBU)) res = {hi_q, lo_q} - prod;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul || is_div) begin
            shadow_d = res;
            cnt_d    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_d  = BUSY;
          end else if (op == OP_MTHI) begin
            hi_d = A;
          end else if (op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      BUSY: begin
        // Any start seen here is dropped; the last count edge commits atomically.
        if (cnt_q <= CW'(1)) begin
          {hi_d, lo_d} = shadow_q;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      shadow_q <= shadow_d;
    end
  end

  assign busy  = (state_q == BUSY);
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign rdata = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit with hand-computed HI/LO/busy expectations.
// Covers MDU_MADD_EN when that macro is defined for the build.
module tb_mdu_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] A = '0, B = '0;
  logic         busy;
  logic [W-1:0] HI, LO, rdata;

  int checks = 0;
  int errors = 0;

  mdu_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start for exactly one edge, then return inputs to NOP.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; A = a; B = b;
    step();
    start = 1'b0; op = 4'd0; A = '0; B = '0;
  endtask

  // Expect busy for n cycles with HI/LO frozen, then the committed result.
  task automatic run_op(input string tag, input int n, input logic [W-1:0] hi0, input logic [W-1:0] lo0,
                        input logic [W-1:0] hi1, input logic [W-1:0] lo1);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_hi_hold"}, HI, hi0);
      chk({tag, "_lo_hold"}, LO, lo0);
      step();
    end
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, HI, hi1);
    chk({tag, "_lo"}, LO, lo1);
  endtask

  initial begin
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b0;
    step();

    issue(4'd1, 32'hFFFF_FFFD, 32'd7);
    run_op("mult", 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    issue(4'd4, 32'd100, 32'd7);
    run_op("divu", 10, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'd2, 32'd14);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    run_op("div_neg", 10, 32'd2, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(4'd3, 32'd5, 32'd0);
    run_op("div_zero", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_ovf", 10, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    issue(4'd4, 32'd5, 32'd0);
    run_op("divu_zero", 10, 32'd0, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF);

    issue(4'd5, 32'h1234, 32'd0);
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    op = 4'd7; #1;
    chk("mfhi_rdata", rdata, 32'h1234);
    op = 4'd8; #1;
    chk("mflo_rdata", rdata, 32'hFFFF_FFFF);
    op = 4'd0; #1;
    chk("nop_rdata", rdata, 32'd0);

    // MULTU 3x4 with MTLO and DIVU attempted mid-flight.
    issue(4'd2, 32'd3, 32'd4);
    chk("ign_c1_busy", {31'd0, busy}, 32'd1);
    step();
    chk("ign_c2_busy", {31'd0, busy}, 32'd1);
    start = 1'b1; op = 4'd6; A = 32'd9;
    step();
    chk("ign_c3_busy", {31'd0, busy}, 32'd1);
    chk("ign_mtlo_lo", LO, 32'hFFFF_FFFF);
    op = 4'd4; A = 32'd100; B = 32'd7;
    step();
    start = 1'b0; op = 4'd0; A = '0; B = '0;
    chk("ign_c4_busy", {31'd0, busy}, 32'd1);
    step();
    chk("ign_c5_busy", {31'd0, busy}, 32'd1);
    step();
    chk("ign_done_busy", {31'd0, busy}, 32'd0);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd12);
    step();
    chk("ign_stays_idle", {31'd0, busy}, 32'd0);

    // Start on the commit edge is dropped; HI/LO keep the multiply result.
    issue(4'd2, 32'd2, 32'd3);
    for (int i = 0; i < 4; i++) step();
    chk("edge_last_busy", {31'd0, busy}, 32'd1);
    start = 1'b1; op = 4'd5; A = 32'hDEAD;
    step();
    start = 1'b0; op = 4'd0; A = '0;
    chk("edge_busy", {31'd0, busy}, 32'd0);
    chk("edge_hi", HI, 32'd0);
    chk("edge_lo", LO, 32'd6);

    // Async reset in busy cycle 4 discards the pending divide.
    issue(4'd4, 32'd100, 32'd7);
    for (int i = 0; i < 3; i++) step();
    chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", HI, 32'd0);
    chk("rst_mid_lo", LO, 32'd0);
    reset = 1'b0;
    step();
    step();
    chk("rst_mid_no_commit", LO, 32'd0);
    issue(4'd1, 32'h0001_0000, 32'h0001_0000);
    run_op("post_rst_mult", 5, 32'd0, 32'd0, 32'd1, 32'd0);

`ifdef MDU_MADD_EN
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    issue(4'd10, 32'd1, 32'd1);
    run_op("maddu", 5, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    issue(4'd11, 32'hFFFF_FFFF, 32'd2);
    run_op("msub", 5, 32'd1, 32'd0, 32'd1, 32'd2);
`else
    issue(4'd9, 32'd7, 32'd7);
    chk("madd_off_busy", {31'd0, busy}, 32'd0);
    chk("madd_off_hi", HI, 32'd1);
    chk("madd_off_lo", LO, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit. It sits beside the single-cycle ALU in the EX stage and owns the HI/LO register pair.
- Implements the mult/multu/div/divu/mthi/mtlo/mfhi/mflo instruction class.
- Iteration latency is modelled by a countdown; results commit atomically at the end of the count.
- Exposes `busy` so the hazard unit can stall any later MDU instruction.

Parameters:
- WIDTH, 32: operand width and width of HI and LO.
- MULT_CYCLES, 5: busy cycles for multiply-class ops. Must be >= 1.
- DIV_CYCLES, 10: busy cycles for divide-class ops. Must be >= 1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  issue strobe for the operation on `op`
- op  input  4  operation code, see encodings below
- A  input  WIDTH  operand rs
- B  input  WIDTH  operand rt
- busy  output  1  high while a multiply/divide is in flight
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register
- rdata  output  WIDTH  combinational: HI when op=MFHI, LO when op=MFLO, else 0

Behaviour:
- Encodings: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9–12 reserved for MADD/MADDU/MSUB/MSUBU (optional feature), 13–15 no-op.
- Reset (async, any time, including mid-operation):
  - state=IDLE, busy=0, HI=0, LO=0, counter=0.
  - Any pending result is discarded.
- IDLE state:
  - On a clock edge with start=1 and a mul/div op:
    - latch the full-width result into shadow registers;
    - load counter with MULT_CYCLES or DIV_CYCLES;
    - go to BUSY.
  - busy rises in the cycle after the start edge.
- BUSY state:
  - counter decrements each edge.
  - On the edge where counter reaches 0: HI/LO take the shadow values, busy falls, state returns to IDLE.
  - busy is high for exactly N cycles, where N is the op's cycle count.
  - The new HI/LO are visible in the first cycle with busy=0.
- start while BUSY: ignored for every op, including MTHI/MTLO. HI, LO and the pending result are unaffected.
- Single-cycle ops:
  - MTHI/MTLO in IDLE with start=1: HI (or LO) := A on that edge; busy stays 0.
  - MFHI/MFLO: need no start. rdata is valid combinationally in every state and returns the current committed HI/LO, never the shadow.
- Multiply result:
  - MULT: signed WIDTH×WIDTH → 2·WIDTH product.
  - MULTU: unsigned WIDTH×WIDTH → 2·WIDTH product.
  - {HI,LO} = product.
- Divide result:
  - LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - Divide by zero (B=0): HI=A, LO=all ones. This is fixed, not undefined.
  - Signed overflow (A=most-negative, B=all ones, DIV): LO=A, HI=0.
- Simultaneous events:
  - start on the same edge that busy falls: ignored, because state is still BUSY at that edge.
  - start on the next edge: accepted normally.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Ops 9–12 are multiply-class with MULT_CYCLES latency.
  - Committed result is {HI,LO} ± product, computed from the {HI,LO} value at the start edge, modulo 2^(2·WIDTH).
  - MADD/MSUB use a signed product; MADDU/MSUBU use an unsigned product.
- Undefined:
  - Ops 9–12 are no-ops: start ignored, busy stays 0, HI/LO unchanged.

Test Plan (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10):
- MULT A=0xFFFFFFFD, B=7 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB. HI/LO unchanged (0) while busy.
- DIVU A=100, B=7 -> busy high 10 cycles; then LO=14, HI=2. DIV A=0xFFFFFFF9, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=5, B=0 -> HI=5, LO=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x1234 in IDLE -> HI=0x1234 next cycle, busy=0. op=MFHI -> rdata=0x1234 with no start.
- MULTU 3×4 issued; MTLO A=9 and DIVU issued at cycle 2 of busy -> both ignored; final HI=0, LO=12 after exactly 5 busy cycles.
- DIVU issued, reset pulsed asynchronously at busy cycle 4 -> busy, HI, LO are 0 immediately. A new MULT issued after reset completes normally.
- (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles.
